// File: rtl/sqrt_req_arb.sv
// -----------------------------------------------------------------------------
// sqrt_req_arb
//   Shares one in-order sqrt_u32 engine between NUM_REQ requesters. A
//   round-robin arbiter grants at most one operand per cycle, an in-order tag
//   FIFO remembers which requester owns each in-flight operation, and results
//   are routed back with that ID. A watchdog and a spurious-result detector
//   drive a sticky error state that only err_clr leaves.
//
// Handshake: requester i transfers an operand on a cycle where
//   req_vld[i] & req_rdy[i] are both high at posedge clk. req_rdy never
//   depends on the requester dropping valid, and a requester must keep
//   req_vld/req_x stable until it sees that transfer. rsp_vld is a one-cycle
//   strobe with no backpressure.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req_vld      per-requester operand valid
//   req_x        packed operands, requester i at [32i+31:32i]
//   req_rdy      one-hot grant (or all-zero)
//   eng_vld_in   operand strobe to the engine, registered
//   eng_x        operand to the engine, registered
//   eng_vld_out  engine result strobe
//   eng_y        engine result
//   rsp_vld      result strobe to requesters
//   rsp_id       requester that owns the result (held between results)
//   rsp_y        result value (held between results)
//   busy         operations outstanding
//   err          sticky error flag
//   err_clr      leaves the error state and flushes all tags
//   done_cnt     completed result count, wraps
// -----------------------------------------------------------------------------
module sqrt_req_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MAX_OUT = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_vld,
    input  logic [32*NUM_REQ-1:0]   req_x,
    output logic [NUM_REQ-1:0]      req_rdy,
    output logic                    eng_vld_in,
    output logic [31:0]             eng_x,
    input  logic                    eng_vld_out,
    input  logic [15:0]             eng_y,
    output logic                    rsp_vld,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             rsp_y,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr,
    output logic [15:0]             done_cnt
);

    localparam int OCC_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ID_W-1:0]    tag_mem [MAX_OUT];
    logic [ID_W-1:0]    rr_q;
    logic [WD_W-1:0]    wd_q;

    logic               eng_vld_in_q;
    logic [31:0]        eng_x_q;
    logic               rsp_vld_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [15:0]        rsp_y_q;
    logic               err_q;
    logic [15:0]        done_cnt_q;

    logic               pop, spur, wd_trip, room, grant_ok, grant, found;
    logic [ID_W-1:0]    win;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // A result is only meaningful when a tag is waiting for it; in ERR all
    // results are ignored, so neither pop nor spurious can fire there.
    assign pop     = eng_vld_out && (occ_q != '0) && (state_q != ST_ERR);
    assign spur    = eng_vld_out && (occ_q == '0) && (state_q != ST_ERR);
    assign wd_trip = (state_q == ST_RUN) && (occ_q != '0) && !eng_vld_out &&
                     (wd_q == WD_W'(TIMEOUT - 1));
    assign room    = (occ_q < OCC_W'(MAX_OUT));

    // No grant on the cycle that enters ERR, so nothing is issued after the
    // fault is detected. A same-cycle pop frees a slot for a full FIFO.
    assign grant_ok = rst_n && (state_q != ST_ERR) && !spur && !wd_trip &&
                      (room || pop);

    // Round-robin search: first valid index at or after the pointer.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign grant = grant_ok && found;

    always_comb begin
        req_rdy = '0;
        if (grant) begin
            req_rdy[win] = 1'b1;
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({grant, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (spur) begin
                    state_d = ST_ERR;
                end else if (grant) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (spur || wd_trip) begin
                    state_d = ST_ERR;
                end else if ((occ_d == '0) && !grant) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            occ_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rr_q         <= '0;
            wd_q         <= '0;
            eng_vld_in_q <= 1'b0;
            eng_x_q      <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_id_q     <= '0;
            rsp_y_q      <= '0;
            err_q        <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            eng_vld_in_q <= grant;
            rsp_vld_q    <= pop;

            if (grant) begin
                eng_x_q <= req_x[int'(win)*32 +: 32];
                rr_q    <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end

            if (pop) begin
                rsp_id_q   <= tag_mem[rd_ptr_q];
                rsp_y_q    <= eng_y;
                done_cnt_q <= done_cnt_q + 1'b1;
            end

            // Clearing the error abandons every in-flight tag.
            if ((state_q == ST_ERR) && err_clr) begin
                occ_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                err_q    <= 1'b0;
            end else begin
                occ_q <= occ_d;
                if (grant) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                if (spur || wd_trip) begin
                    err_q <= 1'b1;
                end
            end

            if ((state_q == ST_ERR) || eng_vld_out || (occ_q == '0)) begin
                wd_q <= '0;
            end else if (state_q == ST_RUN) begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    // Tag storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr_q] <= win;
        end
    end

    assign eng_vld_in = eng_vld_in_q;
    assign eng_x      = eng_x_q;
    assign rsp_vld    = rsp_vld_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_y      = rsp_y_q;
    assign busy       = (occ_q != '0);
    assign err        = err_q;
    assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_sqrt_req_arb.sv
// -----------------------------------------------------------------------------
// tb_sqrt_req_arb
//   Bench for sqrt_req_arb with a behavioural engine model (in-order queue of
//   floor-sqrt results, throttled by eng_budget / eng_fast) and a scoreboard
//   that pushes {id, isqrt(x)} at every grant and pops on every rsp_vld.
// -----------------------------------------------------------------------------
module tb_sqrt_req_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int MAX_OUT = 8;
    localparam int TIMEOUT = 1024;
    localparam int W       = ID_W + 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_vld = '0;
    logic [32*NUM_REQ-1:0] req_x = '0;
    logic [NUM_REQ-1:0]    req_rdy;
    logic                  eng_vld_in;
    logic [31:0]           eng_x;
    logic                  eng_vld_out = 1'b0;
    logic [15:0]           eng_y = '0;
    logic                  rsp_vld;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_y;
    logic                  busy;
    logic                  err;
    logic                  err_clr = 1'b0;
    logic [15:0]           done_cnt;

    int checks = 0;
    int failures = 0;
    int rsp_total = 0;

    logic [W-1:0]  exp_q[$];
    logic [15:0]   eng_q[$];
    int            eng_budget = 0;
    bit            eng_fast = 1'b0;
    bit            eng_inject = 1'b0;
    logic [W-1:0]  mon_e;

    sqrt_req_arb #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .eng_vld_in(eng_vld_in), .eng_x(eng_x),
        .eng_vld_out(eng_vld_out), .eng_y(eng_y),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .busy(busy), .err(err), .err_clr(err_clr), .done_cnt(done_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[15:0];
    endfunction

    // ---------------- engine model ----------------
    always @(posedge clk) begin
        #2;
        eng_vld_out = 1'b0;
        if (!rst_n) begin
            eng_q.delete();
        end else begin
            if (eng_vld_in) eng_q.push_back(isqrt(eng_x));
            if (eng_inject) begin
                eng_vld_out = 1'b1;
                eng_y       = 16'hDEAD;
                eng_inject  = 1'b0;
            end else if (eng_q.size() > 0 && eng_budget > 0 &&
                         (eng_fast || $urandom_range(0, 2) == 0)) begin
                eng_y       = eng_q.pop_front();
                eng_vld_out = 1'b1;
                eng_budget--;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_vld) begin
                rsp_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp got id=%0d y=%0d, required no response",
                             rsp_id, rsp_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({rsp_id, rsp_y} !== mon_e) begin
                        failures++;
                        $display("FAIL rsp_data got id=%0d y=%0d, required id=%0d y=%0d",
                                 rsp_id, rsp_y, mon_e[W-1:16], mon_e[15:0]);
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_vld[i] && req_rdy[i])
                    exp_q.push_back({ID_W'(i), isqrt(req_x[32*i +: 32])});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        req_vld = '0;
        err_clr = 1'b0;
        eng_budget = 0;
        eng_fast = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((busy || exp_q.size() != 0) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (busy || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain busy=%0b pending=%0d, required idle", name, busy, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_vld = '1;
        req_x = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_rdy, eng_vld_in, eng_x, rsp_vld, rsp_id, rsp_y, busy, err, done_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vi=%b x=%h rv=%b id=%0d y=%0d busy=%b err=%b cnt=%0d, required all 0",
                     req_rdy, eng_vld_in, eng_x, rsp_vld, rsp_id, rsp_y, busy, err, done_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_vld = '0;
        exp_q.delete();
    endtask

    task automatic test_single();
        int c;
        do_reset();
        eng_budget = 1000;
        req_x[31:0] = 32'd144;
        req_vld = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant got %b, required 0001", req_rdy);
        end
        @(posedge clk);
        #1 req_vld = '0;
        checks++;
        if (eng_vld_in !== 1'b1 || eng_x !== 32'd144) begin
            failures++;
            $display("FAIL single_issue got vld=%b x=%0d, required vld=1 x=144", eng_vld_in, eng_x);
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!rsp_vld && c < 50);
        checks++;
        if (rsp_vld !== 1'b1 || rsp_id !== 2'd0 || rsp_y !== 16'd12) begin
            failures++;
            $display("FAIL single_rsp got vld=%b id=%0d y=%0d, required vld=1 id=0 y=12", rsp_vld, rsp_id, rsp_y);
        end
        checks++;
        if (done_cnt !== 16'd1) begin
            failures++;
            $display("FAIL single_done_cnt got %0d, required 1", done_cnt);
        end
        drain("single");
    endtask

    task automatic test_rotation();
        int g, cyc, exp_w;
        do_reset();
        eng_budget = 100000;
        req_x = {32'hFFFF_FFFF, 32'd65535, 32'd1, 32'd0};
        req_vld = '1;
        g = 0; cyc = 0; exp_w = 0;
        while (g < 12 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (req_rdy != '0) begin
                checks++;
                if (req_rdy !== (4'b0001 << exp_w)) begin
                    failures++;
                    $display("FAIL rotation_grant%0d got %b, required index %0d", g, req_rdy, exp_w);
                end
                exp_w = (exp_w + 1) % NUM_REQ;
                g++;
            end
        end
        checks++;
        if (g != 12) begin
            failures++;
            $display("FAIL rotation_count got %0d grants, required 12", g);
        end
        @(posedge clk);
        #1 req_vld = '0;
        drain("rotation");
    endtask

    task automatic test_max_out();
        int g, c;
        do_reset();
        eng_fast = 1'b1;
        req_x[31:0] = $urandom;
        req_vld = 4'b0001;
        g = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_rdy[0]) g++;
        end
        checks++;
        if (g != MAX_OUT) begin
            failures++;
            $display("FAIL max_out_issues got %0d, required %0d", g, MAX_OUT);
        end
        checks++;
        if (req_rdy !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL max_out_full got rdy=%b busy=%b, required rdy=0000 busy=1", req_rdy, busy);
        end
        eng_budget = 1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!eng_vld_out && c < 10);
        checks++;
        if (eng_vld_out !== 1'b1 || req_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL max_out_pop_grant got res=%b rdy=%b, required res=1 rdy=0001", eng_vld_out, req_rdy);
        end
        @(negedge clk);
        checks++;
        if (req_rdy !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL max_out_still_full got rdy=%b busy=%b, required rdy=0000 busy=1", req_rdy, busy);
        end
        eng_budget = 100000;
        @(posedge clk);
        #1 req_vld = '0;
        drain("max_out");
    endtask

    task automatic test_timeout();
        int g, cyc;
        bit saw;
        do_reset();
        eng_fast = 1'b1;
        req_x[31:0] = $urandom;
        req_vld = 4'b0001;
        g = 0; cyc = 0;
        while (g < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (req_rdy[0]) g++;
        end
        @(posedge clk);
        #1 req_vld = '0;
        while (!err && cyc < 1100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1000) begin
                checks++;
                if (err !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_early got err=%b at cycle 1000, required 0", err);
                end
            end
        end
        checks++;
        if (err !== 1'b1 || cyc < 1020) begin
            failures++;
            $display("FAIL timeout_trip got err=%b at cycle %0d, required err=1 near 1024", err, cyc);
        end
        @(posedge clk);
        #1 req_vld = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_rdy !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_no_grant got rdy=%b busy=%b, required rdy=0000 busy=1", req_rdy, busy);
        end
        eng_budget = 1;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_vld || eng_vld_in) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_late_result got activity=%b err=%b, required activity=0 err=1", saw, err);
        end
        @(posedge clk);
        #1 req_vld = '0;
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        exp_q.delete();
        eng_q.delete();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got err=%b busy=%b, required err=0 busy=0", err, busy);
        end
        eng_budget = 100000;
        @(posedge clk);
        #1 req_vld = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL timeout_resume got rdy=%b, required 0001", req_rdy);
        end
        @(posedge clk);
        #1 req_vld = '0;
        drain("timeout");
    endtask

    task automatic test_spurious();
        bit saw;
        do_reset();
        @(negedge clk);
        eng_inject = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_vld) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL spurious got rsp=%b err=%b, required rsp=0 err=1", saw, err);
        end
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL spurious_clear got err=%b, required 0", err);
        end
    endtask

    task automatic test_reset_mid();
        int g, cyc;
        do_reset();
        req_x[63:32] = $urandom;
        req_vld = 4'b0010;
        g = 0; cyc = 0;
        while (g < 5 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (req_rdy[1]) g++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_vld = '0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({req_rdy, eng_vld_in, eng_x, rsp_vld, rsp_id, rsp_y, busy, err, done_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_mid got rdy=%b vi=%b x=%h rv=%b id=%0d y=%0d busy=%b err=%b cnt=%0d, required all 0",
                     req_rdy, eng_vld_in, eng_x, rsp_vld, rsp_id, rsp_y, busy, err, done_cnt);
        end
        eng_budget = 100000;
        @(posedge clk);
        #1 req_x[95:64] = $urandom;
        req_vld = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_rdy !== 4'b0100) begin
            failures++;
            $display("FAIL reset_mid_regrant got rdy=%b, required 0100", req_rdy);
        end
        @(posedge clk);
        #1 req_vld = '0;
        drain("reset_mid");
    endtask

    task automatic test_wrap();
        int n, cyc, start;
        do_reset();
        eng_fast = 1'b1;
        eng_budget = 1 << 30;
        start = rsp_total;
        n = 0; cyc = 0;
        req_x[31:0] = $urandom;
        req_vld = 4'b0001;
        while (n < 65536 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (req_vld[0] && req_rdy[0]) n++;
            @(posedge clk);
            #1;
            if (n >= 65536) req_vld = '0;
            else req_x[31:0] = $urandom;
        end
        req_vld = '0;
        drain("wrap");
        checks++;
        if (rsp_total - start != 65536) begin
            failures++;
            $display("FAIL wrap_count got %0d responses, required 65536", rsp_total - start);
        end
        checks++;
        if (done_cnt !== 16'd0) begin
            failures++;
            $display("FAIL wrap_done_cnt got %0d, required 0", done_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_max_out();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
